// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index and pipeline-control FSM states
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pctl_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear and hold
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          inc,
    input  logic          hold,
    output logic [CW-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && !hold && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - stall/flush controller for the 5-stage pipeline latches, PC and halt
module pipeline_control
    import cpu_types_pkg::*;
#(
    parameter int CW    = 16,
    parameter int DRAIN = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ihit,
    input  logic          dhit,
    input  logic          dREN_MEM,
    input  logic          dWEN_MEM,
    input  regbits_t      rs_ID,
    input  regbits_t      rt_ID,
    input  logic          memtoReg_EX,
    input  logic          RegWr_EX,
    input  regbits_t      wdest_EX,
    input  logic          branch_taken_EX,
    input  logic          jump_ID,
    input  logic          halt_EX,
    output logic          pc_en,
    output logic          ifid_enable,
    output logic          ifid_flush,
    output logic          idex_enable,
    output logic          idex_flush,
    output logic          exmem_enable,
    output logic          exmem_flush,
    output logic          memwb_enable,
    output logic          memwb_flush,
    output logic          halt,
    output logic [CW-1:0] cnt_loaduse,
    output logic [CW-1:0] cnt_memstall,
    output logic [CW-1:0] cnt_flush
);

    localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

    pctl_state_t   state, next_state;
    logic [DW-1:0] drain_cnt;
    logic          frozen, load_use;
    logic          load_drain, dec_drain;
    logic          inc_loaduse, inc_memstall, inc_flush, cnt_hold;

    assign frozen   = (dREN_MEM | dWEN_MEM) & ~dhit;
    assign load_use = memtoReg_EX & RegWr_EX & (wdest_EX != 5'd0) &
                      ((wdest_EX == rs_ID) | (wdest_EX == rt_ID));
    assign cnt_hold = (state == cpu_types_pkg::HALTED);

    always_comb begin
        next_state   = state;
        pc_en        = 1'b1;
        ifid_enable  = 1'b1;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b1;
        idex_flush   = 1'b0;
        exmem_enable = 1'b1;
        exmem_flush  = 1'b0;
        memwb_enable = 1'b1;
        memwb_flush  = 1'b0;
        halt         = 1'b0;
        load_drain   = 1'b0;
        dec_drain    = 1'b0;
        inc_loaduse  = 1'b0;
        inc_memstall = 1'b0;
        inc_flush    = 1'b0;

        if (RST) begin
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_enable = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_flush  = 1'b1;
        end else if (state == cpu_types_pkg::HALTED) begin
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_enable = 1'b0;
            halt         = 1'b1;
        end else if (frozen) begin
            // MEM holds its access; WB takes a bubble so the writeback is not repeated
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_flush  = 1'b1;
            inc_memstall = 1'b1;
        end else if (state == cpu_types_pkg::DRAIN) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            dec_drain  = 1'b1;
            if (drain_cnt <= DW'(1))
                next_state = cpu_types_pkg::HALTED;
        end else if (branch_taken_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            inc_flush  = 1'b1;
        end else if (halt_EX) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            load_drain = 1'b1;
            next_state = cpu_types_pkg::DRAIN;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
            inc_loaduse = 1'b1;
        end else if (jump_ID) begin
            pc_en      = ihit;
            ifid_flush = 1'b1;
            inc_flush  = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= cpu_types_pkg::RUN;
            drain_cnt <= '0;
        end else begin
            state <= next_state;
            if (load_drain)
                drain_cnt <= DW'(DRAIN);
            else if (dec_drain)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    sat_counter #(.CW(CW)) u_cnt_loaduse (
        .CLK(CLK), .RST(RST), .inc(inc_loaduse), .hold(cnt_hold), .count(cnt_loaduse)
    );

    sat_counter #(.CW(CW)) u_cnt_memstall (
        .CLK(CLK), .RST(RST), .inc(inc_memstall), .hold(cnt_hold), .count(cnt_memstall)
    );

    sat_counter #(.CW(CW)) u_cnt_flush (
        .CLK(CLK), .RST(RST), .inc(inc_flush), .hold(cnt_hold), .count(cnt_flush)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - scoreboard bench for pipeline_control against a rule-level model
module tb_pipeline_control;

    localparam int CW    = 4;
    localparam int DRAIN = 2;
    localparam int MAXC  = (1 << CW) - 1;

    typedef struct packed {
        logic       rst, ihit, dhit, dren, dwen;
        logic [4:0] rs, rt;
        logic       memto, regwr;
        logic [4:0] wdest;
        logic       br, jmp, hlt;
    } stim_t;

    typedef struct packed {
        logic [9:0]    ctl;
        logic [CW-1:0] lu, ms, fl;
    } exp_t;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, RegWr_EX;
    logic branch_taken_EX, jump_ID, halt_EX;
    logic [4:0] rs_ID, rt_ID, wdest_EX;
    logic pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
    logic exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt;
    logic [CW-1:0] cnt_loaduse, cnt_memstall, cnt_flush;

    always #5 CLK = ~CLK;

    pipeline_control #(.CW(CW), .DRAIN(DRAIN)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM),
        .rs_ID(rs_ID), .rt_ID(rt_ID),
        .memtoReg_EX(memtoReg_EX), .RegWr_EX(RegWr_EX), .wdest_EX(wdest_EX),
        .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID), .halt_EX(halt_EX),
        .pc_en(pc_en), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
        .idex_enable(idex_enable), .idex_flush(idex_flush),
        .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
        .memwb_enable(memwb_enable), .memwb_flush(memwb_flush),
        .halt(halt), .cnt_loaduse(cnt_loaduse), .cnt_memstall(cnt_memstall),
        .cnt_flush(cnt_flush)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: mode flags, cycles of drain left, integer event counts
    bit m_draining, m_halted;
    int m_left, m_lu, m_ms, m_fl;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic exp_t model(input stim_t s);
        bit pc, ie, ifl, de, dfl, ee, efl, we, wfl, h;
        bit frozen, lu;
        exp_t e;
        frozen = (s.dren || s.dwen) && !s.dhit;
        lu = s.memto && s.regwr && s.wdest != 0 && (s.wdest == s.rs || s.wdest == s.rt);
        {pc, ie, ifl, de, dfl, ee, efl, we, wfl, h} = 10'b1_10_10_10_10_0;
        e.lu = CW'(m_lu); e.ms = CW'(m_ms); e.fl = CW'(m_fl);
        if (s.rst) begin
            {pc, ie, ifl, de, dfl, ee, efl, we, wfl, h} = 10'b0_01_01_01_01_0;
            m_draining = 0; m_halted = 0; m_lu = 0; m_ms = 0; m_fl = 0;
        end else if (m_halted) begin
            {pc, ie, ifl, de, dfl, ee, efl, we, wfl, h} = 10'b0_00_00_00_00_1;
        end else if (frozen) begin
            pc = 0; ie = 0; de = 0; ee = 0; wfl = 1;
            m_ms = sat(m_ms);
        end else if (m_draining) begin
            pc = 0; ifl = 1; dfl = 1;
            m_left--;
            if (m_left <= 0) begin m_halted = 1; m_draining = 0; end
        end else if (s.br) begin
            ifl = 1; dfl = 1;
            m_fl = sat(m_fl);
        end else if (s.hlt) begin
            pc = 0; ifl = 1; dfl = 1;
            m_draining = 1; m_left = DRAIN;
        end else if (lu) begin
            pc = 0; ie = 0; dfl = 1;
            m_lu = sat(m_lu);
        end else if (s.jmp) begin
            pc = s.ihit; ifl = 1;
            m_fl = sat(m_fl);
        end else if (!s.ihit) begin
            pc = 0; ifl = 1;
        end
        e.ctl = {pc, ie, ifl, de, dfl, ee, efl, we, wfl, h};
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ihit = 1; s.rs = 5'd1; s.rt = 5'd2; s.wdest = 5'd3;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(posedge CLK);
        #1;
        RST = s.rst; ihit = s.ihit; dhit = s.dhit; dREN_MEM = s.dren; dWEN_MEM = s.dwen;
        rs_ID = s.rs; rt_ID = s.rt; memtoReg_EX = s.memto; RegWr_EX = s.regwr;
        wdest_EX = s.wdest; branch_taken_EX = s.br; jump_ID = s.jmp; halt_EX = s.hlt;
        q.push_back(model(s));
    endtask

    always @(negedge CLK) begin
        exp_t e, g;
        if (q.size() > 0) begin
            e = q.pop_front();
            g.ctl = {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
                     exmem_enable, exmem_flush, memwb_enable, memwb_flush, halt};
            g.lu = cnt_loaduse; g.ms = cnt_memstall; g.fl = cnt_flush;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle %0d outputs: got ctl=%b lu=%0d ms=%0d fl=%0d, expected ctl=%b lu=%0d ms=%0d fl=%0d",
                         cycle, g.ctl, g.lu, g.ms, g.fl, e.ctl, e.lu, e.ms, e.fl);
            end
            cycle++;
        end
    end

    initial begin
        stim_t s;
        int halted_for;

        s = idle(); s.rst = 1;
        repeat (2) apply(s);
        repeat (2) apply(idle());

        s = idle(); s.memto = 1; s.regwr = 1; s.wdest = 5'd5; s.rs = 5'd5;
        apply(s);
        apply(idle());
        s.wdest = 5'd0; s.rs = 5'd0;
        apply(s);
        s = idle(); s.memto = 1; s.regwr = 1; s.wdest = 5'd7; s.rt = 5'd7;
        apply(s);

        s = idle(); s.dren = 1; s.dhit = 0; s.br = 1;
        repeat (3) apply(s);
        s.dhit = 1;
        apply(s);

        s = idle(); s.br = 1; s.ihit = 0;
        apply(s);
        s = idle(); s.jmp = 1; s.ihit = 0;
        apply(s);
        s = idle(); s.ihit = 0;
        apply(s);

        s = idle(); s.br = 1; s.hlt = 1;
        apply(s);

        s = idle(); s.hlt = 1;
        apply(s);
        repeat (4) apply(idle());
        s = idle(); s.rst = 1;
        apply(s);

        s = idle(); s.hlt = 1;
        apply(s);
        apply(idle());
        s = idle(); s.dwen = 1;
        apply(s);
        repeat (3) apply(idle());
        s = idle(); s.rst = 1;
        apply(s);

        s = idle(); s.br = 1;
        repeat (20) apply(s);
        s = idle(); s.jmp = 1;
        apply(s);
        s = idle(); s.hlt = 1;
        apply(s);
        repeat (4) apply(idle());
        s = idle(); s.rst = 1;
        apply(s);
        apply(idle());

        halted_for = 0;
        for (int i = 0; i < 600; i++) begin
            s.rst   = (halted_for > 3) || ($urandom_range(0, 149) == 0);
            s.ihit  = $urandom_range(0, 3) != 0;
            s.dhit  = $urandom_range(0, 1);
            s.dren  = $urandom_range(0, 4) == 0;
            s.dwen  = $urandom_range(0, 6) == 0;
            s.rs    = 5'($urandom_range(0, 7));
            s.rt    = 5'($urandom_range(0, 7));
            s.memto = $urandom_range(0, 1);
            s.regwr = $urandom_range(0, 2) != 0;
            s.wdest = 5'($urandom_range(0, 7));
            s.br    = $urandom_range(0, 5) == 0;
            s.jmp   = $urandom_range(0, 5) == 0;
            s.hlt   = $urandom_range(0, 39) == 0;
            apply(s);
            halted_for = m_halted ? halted_for + 1 : 0;
        end

        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
